// File: rtl/packet_formatter_if.sv
// Formatter-side bundle: arbiter handshake plus the downstream burst bus.
// The formatter drives it through the master modport; its environment uses slave.
interface packet_formatter_if #(
    parameter int DW = 32
);
    logic          f2a_id_req_o;
    logic          f2a_ack_o;
    logic          a2f_val_i;
    logic [1:0]    a2f_id_i;
    logic [DW-1:0] a2f_data_i;
    logic [2:0]    a2f_pkglen_sel_i;
    logic          fmt_req_o;
    logic          fmt_grant_i;
    logic [1:0]    fmt_chid_o;
    logic [5:0]    fmt_length_o;
    logic [DW-1:0] fmt_data_o;
    logic          fmt_start_o;
    logic          fmt_end_o;

    modport master (
        output f2a_id_req_o, f2a_ack_o,
        input  a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i,
        output fmt_req_o,
        input  fmt_grant_i,
        output fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o
    );

    modport slave (
        input  f2a_id_req_o, f2a_ack_o,
        output a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i,
        input  fmt_req_o,
        output fmt_grant_i,
        input  fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o
    );
endinterface

// File: rtl/packet_formatter.sv
// Store-and-forward packet formatter: pulls one packet from the channel arbiter,
// buffers it, then replays it downstream as a single framed burst.
module packet_formatter #(
    parameter int DW    = 32,
    parameter int DEPTH = 32
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    packet_formatter_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, WAIT_GRANT, SEND} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    wr_cnt;
    logic [5:0]    rd_cnt;
    logic [5:0]    len;
    logic [1:0]    chid;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] pkt_buf [DEPTH];

    function automatic logic [5:0] decode_len(input logic [2:0] sel);
        case (sel)
            3'd0:    decode_len = 6'd4;
            3'd1:    decode_len = 6'd8;
            3'd2:    decode_len = 6'd16;
            default: decode_len = 6'd32;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = REQ;
            REQ:        if (bus.a2f_val_i) state_nxt = LOAD;
            LOAD:       if (bus.a2f_val_i && (wr_cnt == len - 6'd1)) state_nxt = WAIT_GRANT;
            WAIT_GRANT: if (bus.fmt_grant_i) state_nxt = SEND;
            SEND:       if (rd_cnt == len - 6'd1) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.f2a_id_req_o = 1'b0;
        bus.f2a_ack_o    = 1'b0;
        bus.fmt_req_o    = 1'b0;
        bus.fmt_data_o   = '0;
        bus.fmt_start_o  = 1'b0;
        bus.fmt_end_o    = 1'b0;
        case (state)
            REQ: begin
                bus.f2a_id_req_o = 1'b1;
                bus.f2a_ack_o    = bus.a2f_val_i;
            end
            LOAD:       bus.f2a_ack_o = bus.a2f_val_i;
            WAIT_GRANT: bus.fmt_req_o = 1'b1;
            SEND: begin
                bus.fmt_data_o  = pkt_buf[rd_idx];
                bus.fmt_start_o = (rd_cnt == 6'd0);
                bus.fmt_end_o   = (rd_cnt == len - 6'd1);
            end
            default: ;
        endcase
    end

    // Id and length are captured only with the first word; later changes are ignored.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_cnt <= 6'd0;
            rd_cnt <= 6'd0;
            len    <= 6'd0;
            chid   <= 2'd0;
        end else begin
            case (state)
                REQ: if (bus.a2f_val_i) begin
                    wr_cnt <= 6'd1;
                    len    <= decode_len(bus.a2f_pkglen_sel_i);
                    chid   <= bus.a2f_id_i;
                end
                LOAD:       if (bus.a2f_val_i) wr_cnt <= wr_cnt + 6'd1;
                WAIT_GRANT: if (bus.fmt_grant_i) rd_cnt <= 6'd0;
                SEND:       rd_cnt <= rd_cnt + 6'd1;
                default: ;
            endcase
        end
    end

    assign wr_en  = ((state == REQ) || (state == LOAD)) && bus.a2f_val_i;
    assign wr_idx = (state == REQ) ? '0 : AW'(wr_cnt);
    assign rd_idx = AW'(rd_cnt);

    // Packet storage carries no reset; contents are only read after being written.
    always_ff @(posedge clk_i) begin
        if (wr_en) pkt_buf[wr_idx] <= bus.a2f_data_i;
    end

    assign bus.fmt_chid_o   = chid;
    assign bus.fmt_length_o = len;
endmodule

// File: tb/tb_packet_formatter.sv
// Randomized bench for packet_formatter with a packet-level reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_packet_formatter;
    localparam int V_CONTIG = 0, V_GAP = 1, V_RAND = 2;
    localparam int M_GAP = 0, M_COLL = 1, M_WAIT = 2, M_BURST = 3;
    localparam int G_RAND = 0, G_AFTER3 = 1, G_PULSE = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    packet_formatter_if #(.DW(32)) bus ();
    packet_formatter #(.DW(32), .DEPTH(32)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int len_tab [8] = '{4, 8, 16, 32, 32, 32, 32, 32};

    // driver / grant control
    int drv_n = 0, drv_len = 4, grant_mode = G_RAND;

    // reference model
    int          m_ph = M_GAP, m_n = 0, m_i = 0, m_plen = 0;
    logic [1:0]  m_chid = 0;
    logic [5:0]  m_len = 0;
    logic [31:0] m_q [$];

    // DUT-side monitor
    int          cyc = 0, mon_ack_n = 0, mon_req_n = 0, req_hi_n = 0, mon_bn = 0, mon_end_n = 0;
    int          mon_last_ack = 0, mon_start = 0, mon_end = 0, mon_rise = 0;
    logic [1:0]  mon_chid = 0, mon_chid_end = 0;
    logic [5:0]  mon_len = 0;
    logic [31:0] mon_bq [$];
    bit          in_b = 0, prev_idreq = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    endfunction

    // Per-cycle comparison against the packet-level model, sampled mid-cycle.
    initial forever begin
        logic        e_idreq, e_ack, e_req, e_start, e_end;
        logic [31:0] e_data;
        @(negedge clk);
        if (!rstn) begin
            chk("rst_idreq", bus.f2a_id_req_o, 0);
            chk("rst_ack",   bus.f2a_ack_o, 0);
            chk("rst_req",   bus.fmt_req_o, 0);
            chk("rst_data",  bus.fmt_data_o, 0);
            chk("rst_start", bus.fmt_start_o, 0);
            chk("rst_end",   bus.fmt_end_o, 0);
            chk("rst_chid",  bus.fmt_chid_o, 0);
            chk("rst_len",   bus.fmt_length_o, 0);
            m_ph = M_GAP; m_chid = 0; m_len = 0; m_q.delete();
            in_b = 0; prev_idreq = 0; req_hi_n = 0;
        end else begin
            cyc++;
            e_idreq = (m_ph == M_COLL) && (m_n == 0);
            e_ack   = (m_ph == M_COLL) && bus.a2f_val_i;
            e_req   = (m_ph == M_WAIT);
            e_data  = (m_ph == M_BURST) ? m_q[m_i] : 32'd0;
            e_start = (m_ph == M_BURST) && (m_i == 0);
            e_end   = (m_ph == M_BURST) && (m_i == m_plen - 1);
            chk("idreq", bus.f2a_id_req_o, e_idreq);
            chk("ack",   bus.f2a_ack_o, e_ack);
            chk("req",   bus.fmt_req_o, e_req);
            chk("data",  bus.fmt_data_o, e_data);
            chk("start", bus.fmt_start_o, e_start);
            chk("end",   bus.fmt_end_o, e_end);
            chk("chid",  bus.fmt_chid_o, m_chid);
            chk("len",   bus.fmt_length_o, m_len);

            if (bus.f2a_ack_o) begin mon_ack_n++; mon_last_ack = cyc; end
            if (bus.fmt_req_o) begin mon_req_n++; req_hi_n++; end else req_hi_n = 0;
            if (bus.fmt_start_o) begin
                in_b = 1; mon_bq.delete(); mon_bn = 0;
                mon_chid = bus.fmt_chid_o; mon_len = bus.fmt_length_o; mon_start = cyc;
            end
            if (in_b) begin mon_bq.push_back(bus.fmt_data_o); mon_bn++; end
            if (bus.fmt_end_o) begin
                in_b = 0; mon_end = cyc; mon_end_n++; mon_chid_end = bus.fmt_chid_o;
            end
            if (bus.f2a_id_req_o && !prev_idreq) mon_rise = cyc;
            prev_idreq = bus.f2a_id_req_o;

            case (m_ph)
                M_GAP: begin m_ph = M_COLL; m_n = 0; end
                M_COLL: if (bus.a2f_val_i) begin
                    if (m_n == 0) begin
                        m_chid = bus.a2f_id_i;
                        m_plen = len_tab[bus.a2f_pkglen_sel_i];
                        m_len  = 6'(m_plen);
                        m_q.delete();
                    end
                    m_q.push_back(bus.a2f_data_i);
                    m_n++;
                    if (m_n == m_plen) m_ph = M_WAIT;
                end
                M_WAIT: if (bus.fmt_grant_i) begin m_ph = M_BURST; m_i = 0; end
                default: begin
                    m_i++;
                    if (m_i == m_plen) m_ph = M_GAP;
                end
            endcase
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (grant_mode)
            G_AFTER3: bus.fmt_grant_i = (req_hi_n >= 3);
            G_PULSE:  bus.fmt_grant_i = (drv_n == 2) || (drv_n + 1 >= drv_len);
            default:  bus.fmt_grant_i = ($urandom_range(0, 3) == 0);
        endcase
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic mon_clear();
        mon_ack_n = 0; mon_req_n = 0; mon_bn = 0; mon_bq.delete();
    endtask

    task automatic send_packet(input logic [1:0] id, input logic [2:0] sel, input int vmode,
                               input bit rnd, input logic [31:0] base, input logic [1:0] id2);
        int guard = 0;
        bit tog = 0;
        drv_n = 0;
        drv_len = len_tab[sel];
        while (drv_n < drv_len && guard < 3000) begin
            @(posedge clk);
            #1;
            if (drv_n == 0)
                bus.a2f_val_i = (vmode == V_RAND) ? ($urandom_range(0, 2) != 0) : bus.f2a_id_req_o;
            else if (vmode == V_GAP) begin bus.a2f_val_i = tog; tog = ~tog; end
            else if (vmode == V_RAND) bus.a2f_val_i = ($urandom_range(0, 2) != 0);
            else bus.a2f_val_i = 1'b1;
            bus.a2f_id_i         = (drv_n == 0) ? id : id2;
            bus.a2f_pkglen_sel_i = (drv_n == 0) ? sel : 3'($urandom_range(0, 7));
            bus.a2f_data_i       = rnd ? $urandom : base + 32'(drv_n);
            @(negedge clk);
            if (bus.a2f_val_i && bus.f2a_ack_o) drv_n++;
            guard++;
        end
        chk("send_words_accepted", drv_n, drv_len);
        @(posedge clk);
        #1;
        bus.a2f_val_i = 1'b0;
    endtask

    task automatic wait_end();
        int start = mon_end_n;
        int k = 0;
        while (mon_end_n == start && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("burst_end_seen", (mon_end_n != start), 1);
    endtask

    initial begin
        int k;
        rstn = 1'b0;
        bus.a2f_val_i = 0; bus.a2f_id_i = 0; bus.a2f_data_i = 0;
        bus.a2f_pkglen_sel_i = 0; bus.fmt_grant_i = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // idle formatter, 4-word packet, late grant
        grant_mode = G_AFTER3;
        mon_clear();
        send_packet(2'd2, 3'd0, V_CONTIG, 0, 32'h100, 2'd2);
        wait_end();
        chk("t1_acks", mon_ack_n, 4);
        chk("t1_chid", mon_chid, 2);
        chk("t1_len", mon_len, 4);
        chk("t1_burst_n", mon_bq.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_word", mon_bq[i], 32'h100 + i);
        chk("t1_req_cycles", mon_req_n, 4);
        repeat (3) @(negedge clk);
        #1 chk("t1_idreq_after_end", mon_rise - mon_end, 2);

        // gapped max-length packet
        grant_mode = G_RAND;
        mon_clear();
        send_packet(2'd0, 3'd3, V_GAP, 0, 32'd0, 2'd0);
        wait_end();
        chk("t2_acks", mon_ack_n, 32);
        chk("t2_len", mon_len, 32);
        chk("t2_burst_n", mon_bq.size(), 32);
        for (int i = 0; i < 32; i++) chk("t2_word", mon_bq[i], i);

        // clamped length code
        mon_clear();
        send_packet(2'd1, 3'd6, V_CONTIG, 1, 32'd0, 2'd1);
        wait_end();
        chk("t3_len", mon_len, 32);
        chk("t3_burst_n", mon_bq.size(), 32);

        // grant pulsed during load, then held before waiting
        grant_mode = G_PULSE;
        mon_clear();
        send_packet(2'd3, 3'd1, V_CONTIG, 1, 32'd0, 2'd3);
        wait_end();
        chk("t4_req_cycles", mon_req_n, 1);
        chk("t4_send_latency", mon_start - mon_last_ack, 2);

        // id change after first word
        grant_mode = G_RAND;
        mon_clear();
        send_packet(2'd1, 3'd1, V_CONTIG, 1, 32'd0, 2'd3);
        wait_end();
        chk("t6_chid_start", mon_chid, 1);
        chk("t6_chid_end", mon_chid_end, 1);

        // reset at the 5th word of a 16-word burst
        mon_clear();
        send_packet(2'd3, 3'd2, V_CONTIG, 1, 32'd0, 2'd3);
        k = 0;
        while (mon_bn != 5 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t5_reached_word5", mon_bn, 5);
        rstn = 1'b0;
        #1;
        chk("t5_async_data", bus.fmt_data_o, 0);
        chk("t5_async_start", bus.fmt_start_o, 0);
        chk("t5_async_end", bus.fmt_end_o, 0);
        chk("t5_async_chid", bus.fmt_chid_o, 0);
        chk("t5_async_len", bus.fmt_length_o, 0);
        chk("t5_async_idreq", bus.f2a_id_req_o, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        mon_clear();
        send_packet(2'd2, 3'd0, V_CONTIG, 0, 32'h200, 2'd2);
        wait_end();
        chk("t5_fresh_chid", mon_chid, 2);
        chk("t5_fresh_burst_n", mon_bq.size(), 4);
        for (int i = 0; i < 4; i++) chk("t5_fresh_word", mon_bq[i], 32'h200 + i);

        // randomized traffic
        for (int p = 0; p < 15; p++) begin
            send_packet(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), V_RAND, 1, 32'd0,
                        2'($urandom_range(0, 3)));
            wait_end();
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
